// File: rtl/sync_handshake_rx.sv
// Receive side of a toggle req/ack CDC handshake: synchronizes req_tgl, captures req_data, streams it out.
// Define SYNC_HANDSHAKE_RX_PREFETCH_EN for a 2-entry output FIFO that acknowledges on capture.
module sync_handshake_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] req_data,
  output logic             ack_tgl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             proto_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   p_q;
  logic                   p_d;
  logic                   evt;
  logic                   ack_d;
  logic                   out_valid_d;
  logic [WIDTH-1:0]       out_data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
    end
  end

  assign s   = sync_q[SYNC_STAGES-1];
  assign evt = s ^ p_q;

  // p only advances on capture, so an uncaptured toggle stays visible as evt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q       <= 1'b0;
      ack_tgl   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      p_q       <= p_d;
      ack_tgl   <= ack_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

`ifdef SYNC_HANDSHAKE_RX_PREFETCH_EN

  logic [WIDTH-1:0] buf_data_q;
  logic [WIDTH-1:0] buf_data_d;
  logic             buf_valid_q;
  logic             buf_valid_d;
  logic             pop;
  logic             push;

  // out_data is the FIFO head; buf holds the second entry
  always_comb begin
    p_d         = p_q;
    ack_d       = ack_tgl;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    pop         = out_valid & out_ready;
    push        = evt & (~buf_valid_q | pop);
    if (push) begin
      p_d   = s;
      ack_d = ~ack_tgl;
    end
    if (pop) begin
      if (buf_valid_q) begin
        out_data_d = buf_data_q;
        if (push) begin
          buf_data_d = req_data;
        end else begin
          buf_valid_d = 1'b0;
        end
      end else if (push) begin
        out_data_d = req_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        out_data_d  = req_data;
        out_valid_d = 1'b1;
      end else begin
        buf_data_d  = req_data;
        buf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign proto_err = 1'b0;

`else

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state_q;
  state_t state_d;
  logic   proto_d;

  // A handshake and a new event on the same HOLD edge: handshake wins, event is caught from IDLE
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    ack_d       = ack_tgl;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    proto_d     = proto_err;
    case (state_q)
      IDLE: begin
        if (evt) begin
          out_data_d  = req_data;
          p_d         = s;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~ack_tgl;
          state_d     = IDLE;
        end
        if (evt) begin
          proto_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      proto_err <= proto_d;
    end
  end

`endif

endmodule

// File: tb/tb_sync_handshake_rx.sv
// Self-checking bench for sync_handshake_rx: sender model with 2-flop ack sync, scoreboard of sent words.
module tb_sync_handshake_rx;

  logic        clk;
  logic        reset_n;
  logic        req_tgl;
  logic [31:0] req_data;
  logic        ack_tgl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        proto_err;

  logic        ack_s1;
  logic        ack_s2;
  logic [31:0] exp_q[$];
  int          checks;
  int          errors;

  sync_handshake_rx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_tgl   (req_tgl),
    .req_data  (req_data),
    .ack_tgl   (ack_tgl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sender-side resynchronizer of the acknowledge toggle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack_tgl;
      ack_s2 <= ack_s1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data);
    req_data = data;
    req_tgl  = ~req_tgl;
    exp_q.push_back(data);
  endtask

  task automatic waitValid(input int max_edges, output int edges);
    edges = 0;
    while (!out_valid && edges < max_edges) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consumeOne(input string tag);
    logic [31:0] exp_word;
    out_ready = 1'b1;
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checkOutput(tag, 64'(out_data), 64'(exp_word));
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          sent;
    int          recv;
    int          ack_changes;
    logic        last_ack;
    logic        stable;
    logic [31:0] held;
    logic [31:0] exp_word;
    logic [31:0] words [3];

    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    req_tgl   = 1'b0;
    req_data  = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_data",  64'(out_data),  64'd0);
    checkOutput("rst_ack",   64'(ack_tgl),   64'd0);
    checkOutput("rst_perr",  64'(proto_err), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] first word latency");
    applyStimulus(32'hA5A5_0001);
    waitValid(8, n);
    checkOutput("first_valid", 64'(out_valid), 64'd1);
    checkOutput("first_latency_3to4", 64'(n >= 3 && n <= 4), 64'd1);
    checkOutput("first_data", 64'(out_data), 64'hA5A5_0001);
`ifdef SYNC_HANDSHAKE_RX_PREFETCH_EN
    checkOutput("first_ack", 64'(ack_tgl), 64'd1);
`else
    checkOutput("first_ack", 64'(ack_tgl), 64'd0);
`endif

    $display("[TB] stall then handshake");
    held   = out_data;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== held) stable = 1'b0;
    end
    checkOutput("hold_stable", 64'(stable), 64'd1);
    consumeOne("hs_word");
    checkOutput("hs_valid_low", 64'(out_valid), 64'd0);
    checkOutput("hs_ack", 64'(ack_tgl), 64'd1);

    $display("[TB] 100 random words with random ready");
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 5000 && recv < 100; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checkOutput("rand_word", 64'(out_data), 64'(exp_word));
        recv++;
      end
      if (sent < 100 && req_tgl == ack_s2 && $urandom_range(0, 3) != 0) begin
        applyStimulus($urandom);
        sent++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checkOutput("rand_recv_count", 64'(recv), 64'd100);
    checkOutput("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("rand_perr", 64'(proto_err), 64'd0);
    repeat (4) @(posedge clk);
    #1;

`ifndef SYNC_HANDSHAKE_RX_PREFETCH_EN
    $display("[TB] second toggle while holding");
    applyStimulus(32'h1111_0001);
    waitValid(8, n);
    applyStimulus(32'h2222_0002);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("perr_set", 64'(proto_err), 64'd1);
    checkOutput("perr_held_data", 64'(out_data), 64'h1111_0001);
    consumeOne("perr_w1");
    waitValid(4, n);
    consumeOne("perr_w2");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("perr_sticky", 64'(proto_err), 64'd1);
    repeat (2) @(posedge clk);
    #1;
`endif

    $display("[TB] async reset while holding");
    applyStimulus(32'h3333_0003);
    waitValid(8, n);
    checkOutput("prereset_valid", 64'(out_valid), 64'd1);
`ifndef SYNC_HANDSHAKE_RX_PREFETCH_EN
    checkOutput("prereset_ack",  64'(ack_tgl),   64'd1);
    checkOutput("prereset_perr", 64'(proto_err), 64'd1);
`endif
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_ack",   64'(ack_tgl),   64'd0);
    checkOutput("async_rst_perr",  64'(proto_err), 64'd0);
    exp_q.delete();
    req_tgl  = 1'b0;
    req_data = 32'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

`ifdef SYNC_HANDSHAKE_RX_PREFETCH_EN
    $display("[TB] prefetch with stalled consumer");
    words[0]    = 32'hC0DE_0001;
    words[1]    = 32'hC0DE_0002;
    words[2]    = 32'hC0DE_0003;
    sent        = 0;
    ack_changes = 0;
    last_ack    = ack_tgl;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent < 3 && req_tgl == ack_s2) begin
        applyStimulus(words[sent]);
        sent++;
      end
      @(posedge clk); #1;
      if (ack_tgl != last_ack) ack_changes++;
      last_ack = ack_tgl;
    end
    checkOutput("pf_sent", 64'(sent), 64'd3);
    checkOutput("pf_ack_changes", 64'(ack_changes), 64'd2);
    checkOutput("pf_third_pending", 64'(req_tgl ^ ack_tgl), 64'd1);
    consumeOne("pf_w1");
    checkOutput("pf_third_ack", 64'(ack_tgl), 64'd1);
    consumeOne("pf_w2");
    waitValid(4, n);
    consumeOne("pf_w3");
    checkOutput("pf_empty_valid", 64'(out_valid), 64'd0);
    checkOutput("pf_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
